// File: rtl/conv_spk_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : conv_spk_dispatcher
// Purpose : Turns binary input spike frames into K*K accumulation events for a
//           conv neuron-core group; sequences channels, oc_phases, time steps.
// Option  : DISPATCH_BUBBLE_EN adds one idle cycle after each spike's events.
// Revision: 1.0  initial release
// ============================================================================
module conv_spk_dispatcher #(
    parameter int IN_CHANNELS        = 2,
    parameter int OUT_CHANNELS       = 4,
    parameter int EC_SIZE            = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int INPUT_FRAME_WIDTH  = 28,
    parameter int OUTPUT_FRAME_WIDTH = 26,
    parameter int NUM_STEPS          = 4,
    parameter int ACTIV_WAIT         = OUTPUT_FRAME_WIDTH*OUTPUT_FRAME_WIDTH+2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    output logic                                         done,
    output logic                                         frame_req,
    output logic [$clog2(IN_CHANNELS)+1:0]               frame_ic,
    input  logic                                         frame_valid,
    input  logic [INPUT_FRAME_WIDTH*INPUT_FRAME_WIDTH-1:0] frame_spk,
    output logic                                         en_accum,
    output logic                                         en_activ,
    output logic                                         neur_addr_invalid,
    output logic [$clog2(INPUT_FRAME_WIDTH)-1:0]         affect_neur_addr_row,
    output logic [$clog2(INPUT_FRAME_WIDTH)-1:0]         affect_neur_addr_col,
    output logic [$clog2(KERNEL_SIZE)+1:0]               filter_phase,
    output logic [$clog2(IN_CHANNELS)+1:0]               ic,
    output logic [$clog2(OUT_CHANNELS)+1:0]              oc_phase,
    output logic                                         ic_done,
    output logic                                         last_time_step
);
    localparam int C_CW   = $clog2(IN_CHANNELS) + 2;
    localparam int C_PW   = $clog2(OUT_CHANNELS) + 2;
    localparam int C_AW   = $clog2(INPUT_FRAME_WIDTH);
    localparam int C_SW   = C_AW + 2;
    localparam int C_FW   = $clog2(KERNEL_SIZE) + 2;
    localparam int C_NPIX = INPUT_FRAME_WIDTH * INPUT_FRAME_WIDTH;
    localparam int C_IW   = $clog2(C_NPIX);
    localparam int C_TW   = $clog2(NUM_STEPS) + 1;
    localparam int C_WW   = $clog2(ACTIV_WAIT + 1);
    localparam int C_NPH  = OUT_CHANNELS / EC_SIZE;
    localparam logic signed [C_SW-1:0] C_OFW = C_SW'(OUTPUT_FRAME_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE, S_PRIME, S_REQ, S_SCAN, S_EMIT,
        S_BUBBLE, S_ICDONE, S_ACTIV, S_WAIT, S_DONE
    } state_t;

    state_t                   r_state, w_next;
    logic [C_NPIX-1:0]        r_work;
    logic [C_AW-1:0]          r_sr, r_sc;
    logic signed [C_SW-1:0]   r_kr, r_kc;
    logic [C_FW-1:0]          r_phase;
    logic [C_CW-1:0]          r_c;
    logic [C_PW-1:0]          r_p;
    logic [C_TW-1:0]          r_t;
    logic [C_WW-1:0]          r_wait;
    logic                     r_last;

    logic                     w_found;
    logic [C_IW-1:0]          w_idx;
    logic [C_AW-1:0]          w_row, w_col;
    logic signed [C_SW-1:0]   w_row_s, w_col_s;
    logic                     w_inv, w_emit_last, w_wait_last, w_run_last;

    // Lowest set bit wins: descending loop lets the smallest index overwrite.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_row   = '0;
        w_col   = '0;
        for (int i = C_NPIX - 1; i >= 0; i--) begin
            if (r_work[i]) begin
                w_found = 1'b1;
                w_idx   = C_IW'(i);
                w_row   = C_AW'(i / INPUT_FRAME_WIDTH);
                w_col   = C_AW'(i % INPUT_FRAME_WIDTH);
            end
        end
    end

    assign w_row_s     = $signed({2'b00, r_sr}) - r_kr;
    assign w_col_s     = $signed({2'b00, r_sc}) - r_kc;
    assign w_inv       = w_row_s[C_SW-1] || w_col_s[C_SW-1] ||
                         (w_row_s >= C_OFW) || (w_col_s >= C_OFW);
    assign w_emit_last = (r_phase == C_FW'(KERNEL_SIZE*KERNEL_SIZE - 1));
    assign w_wait_last = (r_wait == C_WW'(ACTIV_WAIT - 1));
    assign w_run_last  = (r_p == C_PW'(C_NPH - 1)) && (r_t == C_TW'(NUM_STEPS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_PRIME;
            S_PRIME:  w_next = S_REQ;
            S_REQ:    if (frame_valid) w_next = S_SCAN;
            S_SCAN:   w_next = w_found ? S_EMIT : S_ICDONE;
`ifdef DISPATCH_BUBBLE_EN
            S_EMIT:   if (w_emit_last) w_next = S_BUBBLE;
            S_BUBBLE: w_next = S_SCAN;
`else
            S_EMIT:   if (w_emit_last) w_next = S_SCAN;
`endif
            S_ICDONE: w_next = (r_c == C_CW'(IN_CHANNELS - 1)) ? S_ACTIV : S_REQ;
            S_ACTIV:  w_next = S_WAIT;
            S_WAIT:   if (w_wait_last) w_next = w_run_last ? S_DONE : S_PRIME;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        done                 = 1'b0;
        frame_req            = 1'b0;
        en_accum             = 1'b0;
        en_activ             = 1'b0;
        neur_addr_invalid    = 1'b0;
        affect_neur_addr_row = '0;
        affect_neur_addr_col = '0;
        filter_phase         = '0;
        ic_done              = 1'b0;
        case (r_state)
            S_PRIME: begin
                en_accum          = 1'b1;
                neur_addr_invalid = 1'b1;
            end
            S_REQ:    frame_req = 1'b1;
            S_EMIT: begin
                en_accum          = 1'b1;
                filter_phase      = r_phase;
                neur_addr_invalid = w_inv;
                if (!w_inv) begin
                    affect_neur_addr_row = w_row_s[C_AW-1:0];
                    affect_neur_addr_col = w_col_s[C_AW-1:0];
                end
            end
            S_ICDONE: ic_done  = 1'b1;
            S_ACTIV:  en_activ = 1'b1;
            S_DONE:   done     = 1'b1;
            default: ;
        endcase
    end

    assign frame_ic       = r_c;
    assign ic             = r_c;
    assign oc_phase       = r_p;
    assign last_time_step = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_sr    <= '0;
            r_sc    <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_phase <= '0;
            r_c     <= '0;
            r_p     <= '0;
            r_t     <= '0;
            r_wait  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_c    <= '0;
                    r_p    <= '0;
                    r_t    <= '0;
                    r_last <= (NUM_STEPS == 1);
                end
                S_REQ: if (frame_valid) r_work <= frame_spk;
                S_SCAN: if (w_found) begin
                    r_sr          <= w_row;
                    r_sc          <= w_col;
                    r_work[w_idx] <= 1'b0;
                    r_kr          <= '0;
                    r_kc          <= '0;
                    r_phase       <= '0;
                end
                S_EMIT: begin
                    r_phase <= r_phase + C_FW'(1);
                    if (r_kc == C_SW'(KERNEL_SIZE - 1)) begin
                        r_kc <= '0;
                        r_kr <= r_kr + C_SW'(1);
                    end else begin
                        r_kc <= r_kc + C_SW'(1);
                    end
                end
                S_ICDONE: r_c <= (r_c == C_CW'(IN_CHANNELS - 1)) ? '0 : r_c + C_CW'(1);
                S_ACTIV:  r_wait <= '0;
                S_WAIT: begin
                    r_wait <= r_wait + C_WW'(1);
                    if (w_wait_last) begin
                        if (r_p == C_PW'(C_NPH - 1)) begin
                            r_p <= '0;
                            if (r_t != C_TW'(NUM_STEPS - 1)) begin
                                r_t    <= r_t + C_TW'(1);
                                r_last <= (r_t == C_TW'(NUM_STEPS - 2));
                            end
                        end else begin
                            r_p <= r_p + C_PW'(1);
                        end
                    end
                end
                S_DONE:   r_last <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_spk_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_conv_spk_dispatcher
// Purpose : Self-checking bench: event scoreboard, vector table, corner runs.
// Revision: 1.0  initial release
// ============================================================================
module tb_conv_spk_dispatcher;
    localparam int W = 28, OW = 26, K = 3, NS = 2, NPH = 2, NCH = 2;
    localparam int AWAIT = 678, NPIX = W * W;
`ifdef DISPATCH_BUBBLE_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    logic            clk = 1'b0, rst_n, start, frame_valid;
    logic [NPIX-1:0] frame_spk;
    logic            done, frame_req, en_accum, en_activ, neur_addr_invalid, ic_done, last_time_step;
    logic [2:0]      frame_ic, ic;
    logic [4:0]      row, col;
    logic [3:0]      filter_phase, oc_phase;

    conv_spk_dispatcher #(.NUM_STEPS(NS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .frame_req(frame_req), .frame_ic(frame_ic), .frame_valid(frame_valid),
        .frame_spk(frame_spk), .en_accum(en_accum), .en_activ(en_activ),
        .neur_addr_invalid(neur_addr_invalid), .affect_neur_addr_row(row),
        .affect_neur_addr_col(col), .filter_phase(filter_phase), .ic(ic),
        .oc_phase(oc_phase), .ic_done(ic_done), .last_time_step(last_time_step)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic inv; logic [4:0] row; logic [4:0] col; logic [3:0] ph;} ev_t;
    typedef struct {int r; int c; logic [8:0] mask; int nvalid; int naccum;} vec_t;

    ev_t             q[$];
    logic [NPIX-1:0] frames[NCH];
    int n_chk = 0, n_pass = 0;
    int exp_c, mp, mt, wcnt, dly, req_delay = 0, cyc = 0, last_acc = 0;
    int n_activ, n_icdone, n_done, n_accum, n_valid;
    bit exp_done, wait_busy, gap_armed;
    logic [8:0] vmask;

    task automatic check(input string nm, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic ev_t mk_ev(input bit inv, input int r, input int c, input int ph);
        ev_t e;
        e.inv = inv;
        e.row = inv ? 5'd0 : r[4:0];
        e.col = inv ? 5'd0 : c[4:0];
        e.ph  = ph[3:0];
        return e;
    endfunction

    task automatic push_frame(input logic [NPIX-1:0] f);
        int rr, cc;
        bit inv;
        for (int i = 0; i < NPIX; i++) begin
            if (f[i]) begin
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        rr  = i / W - kr;
                        cc  = i % W - kc;
                        inv = (rr < 0) || (cc < 0) || (rr >= OW) || (cc >= OW);
                        q.push_back(mk_ev(inv, rr, cc, kr * K + kc));
                    end
                end
            end
        end
    endtask

    // Frame responder, expected-event model and output monitor.
    initial begin
        ev_t e, got;
        frame_valid = 1'b0;
        frame_spk   = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                q.delete();
                frame_valid = 1'b0;
                dly = 0; wcnt = 0; exp_done = 0; wait_busy = 0; gap_armed = 0;
                continue;
            end
            if (start) begin
                q.push_back(mk_ev(1, 0, 0, 0));
                mt = 0; mp = 0; exp_c = 0;
                n_activ = 0; n_icdone = 0; n_done = 0; n_accum = 0; n_valid = 0; vmask = '0;
            end
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt > 0) begin
                    if (frame_req || en_accum || en_activ || ic_done || done) wait_busy = 1;
                end else begin
                    check("wait_idle", !wait_busy, wait_busy, 0);
                    wait_busy = 0;
                    if (mp < NPH - 1) begin
                        mp++;
                        q.push_back(mk_ev(1, 0, 0, 0));
                    end else begin
                        mp = 0;
                        if (mt < NS - 1) begin
                            mt++;
                            q.push_back(mk_ev(1, 0, 0, 0));
                        end else exp_done = 1;
                    end
                end
            end
            if (frame_valid) begin
                frame_valid = 1'b0;
                push_frame(frames[exp_c]);
                exp_c = (exp_c + 1) % NCH;
                for (int i = 0; i < NPIX; i++) frame_spk[i] = 1'($urandom_range(0, 1));
            end else if (frame_req) begin
                if (dly < req_delay) dly++;
                else begin
                    dly = 0;
                    check("frame_ic_phase", (frame_ic == 3'(exp_c)) && (oc_phase == 4'(mp)),
                          frame_ic * 16 + oc_phase, exp_c * 16 + mp);
                    frame_valid = 1'b1;
                    frame_spk   = frames[exp_c];
                end
            end
            if (en_accum) begin
                n_accum++;
                check("accum_expected", q.size() != 0, q.size(), 1);
                if (q.size() != 0) begin
                    e   = q.pop_front();
                    got = {neur_addr_invalid, row, col, filter_phase};
                    check("event", got == e, got, e);
                end
                if (gap_armed && filter_phase == 0)
                    check("spike_gap", (cyc - last_acc - 1) == GAP, cyc - last_acc - 1, GAP);
                gap_armed = (filter_phase == 4'(K * K - 1));
                last_acc  = cyc;
                if (!neur_addr_invalid) begin
                    n_valid++;
                    if (filter_phase < 9) vmask[filter_phase] = 1'b1;
                end
            end
            if (ic_done) begin
                n_icdone++;
                gap_armed = 0;
                check("ic_done_drained", q.size() == 0, q.size(), 0);
            end
            if (en_activ) begin
                n_activ++;
                check("activ_state", !en_accum && (last_time_step == (mt == NS - 1)) && q.size() == 0,
                      {en_accum, last_time_step}, {1'b0, mt == NS - 1});
                wcnt = AWAIT + 1;
                wait_busy = 0;
            end
            if (done || exp_done) begin
                if (done) n_done++;
                check("done_timing", done == exp_done, done, exp_done);
                exp_done = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_activ(input int target, input int limit);
        for (int i = 0; i < limit && n_activ < target; i++) @(posedge clk);
        #2;
        check("activ_timeout", n_activ >= target, n_activ, target);
    endtask

    function automatic logic [NPIX-1:0] spikes(input int r, input int c0, input int n);
        logic [NPIX-1:0] f = '0;
        for (int j = 0; j < n; j++) f[r * W + c0 + j] = 1'b1;
        return f;
    endfunction

    initial begin
        vec_t vt[7];
        logic [50:0] outs;
        vt[0] = '{0, 0, 9'b000000001, 1, 10};
        vt[1] = '{27, 27, 9'b100000000, 1, 10};
        vt[2] = '{5, 5, 9'b111111111, 9, 10};
        vt[3] = '{0, 27, 9'b000000100, 1, 10};
        vt[4] = '{27, 0, 9'b001000000, 1, 10};
        vt[5] = '{1, 26, 9'b000110110, 4, 10};
        vt[6] = '{-1, -1, 9'b000000000, 0, 1};

        rst_n = 1'b0; start = 1'b0;
        frames[0] = '0; frames[1] = '0;
        #3;
        outs = {done, frame_req, frame_ic, en_accum, en_activ, neur_addr_invalid, row, col,
                filter_phase, ic, oc_phase, ic_done, last_time_step};
        check("reset_outputs", outs == '0, outs, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            do_reset();
            frames[0] = (vt[v].r >= 0) ? spikes(vt[v].r, vt[v].c, 1) : '0;
            frames[1] = '0;
            run_start();
            wait_activ(1, 400);
            check($sformatf("vec%0d_mask", v), vmask == vt[v].mask, vmask, vt[v].mask);
            check($sformatf("vec%0d_nvalid", v), n_valid == vt[v].nvalid, n_valid, vt[v].nvalid);
            check($sformatf("vec%0d_naccum", v), n_accum == vt[v].naccum, n_accum, vt[v].naccum);
        end

        // Full inference: two time steps, two oc_phases, two spikes per frame.
        do_reset();
        frames[0] = spikes(5, 5, 2);
        frames[1] = spikes(5, 5, 2);
        run_start();
        for (int i = 0; i < 8000 && n_done == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        check("full_done_count", n_done == 1, n_done, 1);
        check("full_activ_count", n_activ == 4, n_activ, 4);
        check("full_icdone_count", n_icdone == 8, n_icdone, 8);
        check("full_valid_events", n_valid == 144, n_valid, 144);
        check("full_idle_after", {frame_req, en_accum, last_time_step} == 3'b000,
              {frame_req, en_accum, last_time_step}, 0);

        // Delayed frame_valid: request held, no events until after SCAN.
        do_reset();
        req_delay = 7;
        frames[0] = spikes(5, 5, 1);
        frames[1] = '0;
        run_start();
        for (int i = 0; i < 20 && !frame_req; i++) begin
            @(posedge clk);
            #2;
        end
        check("req_seen", frame_req, frame_req, 1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #2;
            check("req_held", {frame_req, en_accum} == 2'b10, {frame_req, en_accum}, 2);
        end
        @(posedge clk);
        #2;
        check("scan_cycle", {frame_req, en_accum} == 2'b00, {frame_req, en_accum}, 0);
        @(posedge clk);
        #2;
        check("events_resume", en_accum && filter_phase == 0, {en_accum, filter_phase}, 16);
        wait_activ(1, 400);
        req_delay = 0;

        // Asynchronous reset in the middle of the third spike's events.
        do_reset();
        frames[0] = spikes(5, 5, 3);
        frames[1] = '0;
        run_start();
        for (int i = 0; i < 200 && n_accum < 22; i++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        outs = {done, frame_req, frame_ic, en_accum, en_activ, neur_addr_invalid, row, col,
                filter_phase, ic, oc_phase, ic_done, last_time_step};
        check("async_reset_outputs", outs == '0, outs, 0);
        repeat (3) @(negedge clk);
        check("no_done_after_abort", n_done == 0, n_done, 0);
        rst_n = 1'b1;
        frames[0] = spikes(5, 5, 1);
        run_start();
        for (int i = 0; i < 20 && !frame_req; i++) begin
            @(posedge clk);
            #2;
        end
        check("restart_state", frame_req && ic == 0 && oc_phase == 0 && !last_time_step,
              {frame_req, ic, oc_phase, last_time_step}, 9'b100000000);
        wait_activ(1, 400);
        check("restart_valid", n_valid == 9, n_valid, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected 0", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
